// File: rtl/hit_channel_arbiter_if.sv
// Channel-side and storage-side handshake bundle for hit_channel_arbiter.
// master = arbiter view, slave = the sources/storage environment view.
interface hit_channel_arbiter_if #(
  parameter int unsigned NCHANNELS = 4,
  parameter int unsigned SSIDBITS  = 12,
  parameter int unsigned NCOLS_HLM = 8
);
  localparam int unsigned GW = $clog2(NCHANNELS);

  logic [NCHANNELS-1:0]           chNewAddress;
  logic [NCHANNELS*SSIDBITS-1:0]  chSSID;
  logic [NCHANNELS*NCOLS_HLM-1:0] chHitInfo;
  logic [NCHANNELS-1:0]           chReady;
  logic                           storageReady;
  logic                           newAddress;
  logic [SSIDBITS-1:0]            SSID;
  logic [NCOLS_HLM-1:0]           hitInfo;
  logic [GW-1:0]                  grantChannel;

  modport master (
    input  chNewAddress, chSSID, chHitInfo, storageReady,
    output chReady, newAddress, SSID, hitInfo, grantChannel
  );

  modport slave (
    output chNewAddress, chSSID, chHitInfo, storageReady,
    input  chReady, newAddress, SSID, hitInfo, grantChannel
  );
endinterface

// File: rtl/hit_channel_arbiter.sv
// Per-channel hit FIFOs served round-robin into a single storage write port,
// with clear/run/drain/read sequencing so no hit is lost or written mid-read.
module hit_channel_arbiter #(
  parameter int unsigned NCHANNELS = 4,
  parameter int unsigned SSIDBITS  = 12,
  parameter int unsigned NCOLS_HLM = 8,
  parameter int unsigned FIFODEPTH = 4,
  parameter int unsigned DROPBITS  = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  clearMemory,
  input  logic                  readMemory,
  output logic                  readActive,
  output logic [DROPBITS-1:0]   dropCount,
  hit_channel_arbiter_if.master bus
);
  localparam int unsigned GW = $clog2(NCHANNELS);
  localparam int unsigned AW = $clog2(FIFODEPTH);
  localparam logic [AW:0] PTRONE = (AW+1)'(1);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN, READ} arbStateT;

  arbStateT state, nextState;

  logic [NCHANNELS-1:0] empty, full, push, pop, chReadyInt, dropMask;
  logic [SSIDBITS-1:0]  headSSID [NCHANNELS];
  logic [NCOLS_HLM-1:0] headHit  [NCHANNELS];
  logic [GW-1:0]        rrPtr, grantIdx;
  logic                 anyPending, issueEn, countDrops, flush, issue;
  logic [DROPBITS:0]    dropSum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  for (genvar c = 0; c < NCHANNELS; c++) begin : gChan
    logic [SSIDBITS-1:0]  memSSID [FIFODEPTH];
    logic [NCOLS_HLM-1:0] memHit  [FIFODEPTH];
    logic [AW:0]          wrPtr, rdPtr;

    assign empty[c]    = (wrPtr == rdPtr);
    assign full[c]     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign push[c]     = bus.chNewAddress[c] & chReadyInt[c];
    assign pop[c]      = issue && (grantIdx == GW'(c));
    assign headSSID[c] = memSSID[rdPtr[AW-1:0]];
    assign headHit[c]  = memHit[rdPtr[AW-1:0]];

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push[c]) wrPtr <= wrPtr + PTRONE;
        if (pop[c])  rdPtr <= rdPtr + PTRONE;
      end
    end

    always_ff @(posedge clock) begin
      if (push[c]) begin
        memSSID[wrPtr[AW-1:0]] <= bus.chSSID[c*SSIDBITS +: SSIDBITS];
        memHit[wrPtr[AW-1:0]]  <= bus.chHitInfo[c*NCOLS_HLM +: NCOLS_HLM];
      end
    end
  end

  // First non-empty channel at or above the round-robin pointer, with wrap.
  always_comb begin
    int unsigned probe;
    grantIdx   = '0;
    anyPending = 1'b0;
    probe      = 0;
    for (int unsigned i = 0; i < NCHANNELS; i++) begin
      probe = 32'(rrPtr) + i;
      if (probe >= NCHANNELS) probe = probe - NCHANNELS;
      if (!anyPending && !empty[GW'(probe)]) begin
        anyPending = 1'b1;
        grantIdx   = GW'(probe);
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= CLEAR;
    else         state <= nextState;
  end

  always_comb begin
    nextState  = state;
    chReadyInt = '0;
    readActive = 1'b0;
    issueEn    = 1'b0;
    countDrops = 1'b0;
    case (state)
      CLEAR: begin
        if (bus.storageReady) nextState = RUN;
      end
      RUN: begin
        chReadyInt = ~full;
        issueEn    = 1'b1;
        countDrops = 1'b1;
        if (readMemory) nextState = DRAIN;
      end
      DRAIN: begin
        issueEn    = 1'b1;
        countDrops = 1'b1;
        if ((&empty) && !bus.newAddress && bus.storageReady) nextState = READ;
      end
      READ: begin
        readActive = 1'b1;
        if (!readMemory) nextState = RUN;
      end
      default: nextState = CLEAR;
    endcase
    if (clearMemory) nextState = CLEAR;
  end

  assign bus.chReady = chReadyInt;
  assign flush       = clearMemory || (state == CLEAR);
  // Clear on the same edge kills any issue that would otherwise launch.
  assign issue       = issueEn && bus.storageReady && !bus.newAddress && anyPending && !clearMemory;
  assign dropMask    = countDrops ? (bus.chNewAddress & ~chReadyInt) : '0;
  assign dropSum     = {1'b0, dropCount} + (DROPBITS+1)'($countones(dropMask));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bus.newAddress   <= 1'b0;
      bus.SSID         <= '0;
      bus.hitInfo      <= '0;
      bus.grantChannel <= '0;
      rrPtr            <= '0;
      dropCount        <= '0;
    end else begin
      bus.newAddress <= issue;
      if (issue) begin
        bus.SSID         <= headSSID[grantIdx];
        bus.hitInfo      <= headHit[grantIdx];
        bus.grantChannel <= grantIdx;
        rrPtr            <= (grantIdx == GW'(NCHANNELS-1)) ? '0 : grantIdx + GW'(1);
      end
      dropCount <= dropSum[DROPBITS] ? '1 : dropSum[DROPBITS-1:0];
    end
  end
endmodule

// File: doc/hit_channel_arbiter.md
Name: hit_channel_arbiter

Overview:
- Multi-channel front end between NCHANNELS hit-address sources and one hit-list storage block.
- Generalises the single-counter-to-storage link: each channel gets a small FIFO, channels are served round-robin into the storage's single newAddress/storageReady handshake, and clear/read phases are sequenced so no hit is lost or written mid-read.

Parameters:
- NCHANNELS, 4, number of input channels (2..16).
- SSIDBITS, 12, width of SSID.
- NCOLS_HLM, 8, width of hitInfo.
- FIFODEPTH, 4, entries per channel FIFO; power of 2, minimum 2.
- DROPBITS, 16, width of the saturating drop counter.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- clearMemory  in  1  level; request storage clear and flush of all channel FIFOs.
- readMemory  in  1  level; request readout mode.
- chNewAddress  in  NCHANNELS  per-channel write strobe.
- chSSID  in  NCHANNELS*SSIDBITS  channel c occupies bits [c*SSIDBITS +: SSIDBITS].
- chHitInfo  in  NCHANNELS*NCOLS_HLM  packed the same way as chSSID.
- chReady  out  NCHANNELS  channel FIFO accepts a write this cycle.
- storageReady  in  1  storage can accept a word.
- newAddress  out  1  one-cycle write pulse to storage.
- SSID  out  SSIDBITS  registered SSID, valid while newAddress=1.
- hitInfo  out  NCOLS_HLM  registered hitInfo, valid while newAddress=1.
- grantChannel  out  clog2(NCHANNELS)  source channel of the current newAddress.
- readActive  out  1  storage is quiescent and in read mode.
- dropCount  out  DROPBITS  saturating count of rejected strobes.

Behaviour:
- Reset (resetN=0, asynchronous):
  - FSM=CLEAR, all FIFOs empty, RR pointer=0.
  - newAddress, SSID, hitInfo, grantChannel, chReady, readActive and dropCount are all 0.
- FSM states:
  - CLEAR:
    - chReady=0; FIFOs are held empty; no issues.
    - Go to RUN when clearMemory=0 and storageReady=1.
  - RUN:
    - chReady[c] = ~full[c].
    - readMemory=1 -> DRAIN.
  - DRAIN:
    - chReady=0; issuing continues.
    - Go to READ when all FIFOs are empty, newAddress=0 and storageReady=1.
  - READ:
    - readActive=1, chReady=0, no issues.
    - readMemory=0 -> RUN.
- clearMemory=1 in any state:
  - Next state is CLEAR and all FIFOs are flushed in the same edge.
  - Any newAddress pulse in flight on that edge is suppressed.
  - clearMemory has priority over readMemory.
- Write side:
  - Push channel c when chNewAddress[c]=1 and chReady[c]=1.
  - chNewAddress[c]=1 with chReady[c]=0 in RUN or DRAIN is a drop: dropCount += 1, saturating at all-ones.
  - Strobes in CLEAR or READ are ignored and not counted.
  - Several channels dropping in the same cycle add their popcount.
  - A full FIFO does not accept a push even if it is popped in the same cycle; chReady depends on full only.
- Issue side (RUN or DRAIN):
  - Issue when storageReady=1, newAddress was 0 in the previous cycle, and at least one FIFO is non-empty.
  - Maximum rate is one word per 2 cycles, which gives storage a cycle to drop storageReady.
  - Grant goes to the first non-empty channel searching from the RR pointer upward, with wrap.
  - Pop that FIFO head; register SSID, hitInfo and grantChannel; assert newAddress for exactly 1 cycle.
  - RR pointer = grant+1 mod NCHANNELS.
- Latency:
  - A push into an empty FIFO with an idle arbiter produces newAddress 2 cycles later: cycle 1 FIFO write, cycle 2 registered output.
- Each channel's FIFO preserves order; hits are not reordered within a channel.
- Outputs other than newAddress hold their last values when idle.

Test Plan:
- Reset, hold storageReady=1, clearMemory=0 -> RUN on the 1st edge after reset; chReady=4'b1111.
- Single hit: ch2 writes SSID=0x0A5, hitInfo=0x3C -> 2 cycles later newAddress=1 for 1 cycle, SSID=0x0A5, hitInfo=0x3C, grantChannel=2.
- Fairness: all 4 channels write 1 hit in the same cycle, storageReady=1 -> grants 0,1,2,3 on cycles t+2, t+4, t+6, t+8.
- Overflow: storageReady=0, ch1 strobes 6 times with FIFODEPTH=4 -> chReady[1]=0 after the 4th push, dropCount=2; on release, exactly 4 words issue in order.
- Read sequencing: 3 hits queued, readMemory=1 -> chReady=0 immediately, 3 issues complete, then readActive=1; readMemory=0 -> RUN, chReady restored.
- Clear mid-operation: 2 hits queued, clearMemory pulse -> no further newAddress, FIFOs empty, stays in CLEAR until storageReady=1, dropCount unchanged; resetN low mid-issue -> newAddress=0 asynchronously.
